pipe_ctrl: RTL and testbench

Pipelined main control unit for the RV32I core: decodes the 7-bit opcode in ID, detects load-use hazards, and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers with stall and flush. It generalises the single-cycle opcode decoder with registered stages, wider opcode coverage (JAL, JALR, LUI, AUIPC), hazard handling and saturating event counters. It sits beside the datapath pipeline registers, and each stage reads its control signals from this block.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_if.sv | 46 ++++
 rtl/ctrl_decode.sv | 84 ++++++++
 rtl/pipe_ctrl.sv | 92 +++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pipelined main control unit.
package ctrl_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned OPC_W   = 7;

  localparam logic [OPC_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BR    = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC = 7'b0010111;

  // ALU class: funct-decoded R-type, plain add, funct-decoded imm/branch, load address.
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FN    = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_LOAD  = 2'b11;

  typedef struct packed {
    logic               valid;
    logic               alusrc;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_W-1:0]   rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-side inputs and per-stage control outputs of the pipeline control unit.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic                           id_valid;
  logic [ctrl_pkg::OPC_W-1:0]     opcode;
  logic [ctrl_pkg::REG_W-1:0]     rs1;
  logic [ctrl_pkg::REG_W-1:0]     rs2;
  logic [ctrl_pkg::REG_W-1:0]     rd;
  logic                           ex_flush;

  logic                           stall;
  logic                           id_illegal;
  logic                           ex_alusrc;
  logic                           ex_branch;
  logic                           ex_jump;
  logic [ctrl_pkg::ALUOP_W-1:0]   ex_aluop;
  logic                           mem_read;
  logic                           mem_write;
  logic                           wb_regwrite;
  logic                           wb_memtoreg;
  logic [ctrl_pkg::REG_W-1:0]     ex_rd;
  logic [ctrl_pkg::REG_W-1:0]     mem_rd;
  logic [ctrl_pkg::REG_W-1:0]     wb_rd;
  logic                           illegal_seen;
  logic [CNT_W-1:0]               stall_cnt;
  logic [CNT_W-1:0]               flush_cnt;

  // Datapath / stimulus side.
  modport master (
    output id_valid, opcode, rs1, rs2, rd, ex_flush,
    input  stall, id_illegal, ex_alusrc, ex_branch, ex_jump, ex_aluop,
           mem_read, mem_write, wb_regwrite, wb_memtoreg,
           ex_rd, mem_rd, wb_rd, illegal_seen, stall_cnt, flush_cnt
  );

  // Control unit side.
  modport slave (
    input  id_valid, opcode, rs1, rs2, rd, ex_flush,
    output stall, id_illegal, ex_alusrc, ex_branch, ex_jump, ex_aluop,
           mem_read, mem_write, wb_regwrite, wb_memtoreg,
           ex_rd, mem_rd, wb_rd, illegal_seen, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I main decoder: opcode and rd to a control bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [REG_W-1:0] i_rd,
  output ctrl_t            o_ctrl,
  output logic             o_uses_rs1,
  output logic             o_uses_rs2,
  output logic             o_illegal
);

  ctrl_t w_raw;

  // Opcode table; unknown opcodes leave an all-zero, invalid bundle.
  always_comb begin
    w_raw      = CTRL_BUBBLE;
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    o_illegal  = 1'b0;
    case (i_opcode)
      OP_R: begin
        w_raw.regwrite = 1'b1;
        w_raw.aluop    = ALUOP_RTYPE;
        o_uses_rs1     = 1'b1;
        o_uses_rs2     = 1'b1;
      end
      OP_I: begin
        w_raw.alusrc   = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw.aluop    = ALUOP_FN;
        o_uses_rs1     = 1'b1;
      end
      OP_LW: begin
        w_raw.alusrc   = 1'b1;
        w_raw.memtoreg = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw.memread  = 1'b1;
        w_raw.aluop    = ALUOP_LOAD;
        o_uses_rs1     = 1'b1;
      end
      OP_SW: begin
        w_raw.alusrc   = 1'b1;
        w_raw.memwrite = 1'b1;
        w_raw.aluop    = ALUOP_ADD;
        o_uses_rs1     = 1'b1;
        o_uses_rs2     = 1'b1;
      end
      OP_BR: begin
        w_raw.branch   = 1'b1;
        w_raw.aluop    = ALUOP_FN;
        o_uses_rs1     = 1'b1;
        o_uses_rs2     = 1'b1;
      end
      OP_JAL: begin
        w_raw.regwrite = 1'b1;
        w_raw.jump     = 1'b1;
        w_raw.aluop    = ALUOP_ADD;
      end
      OP_JALR: begin
        w_raw.alusrc   = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw.jump     = 1'b1;
        w_raw.aluop    = ALUOP_ADD;
        o_uses_rs1     = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_raw.alusrc   = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw.aluop    = ALUOP_ADD;
      end
      default: o_illegal = 1'b1;
    endcase
    w_raw.valid = ~o_illegal;
  end

  // Writes to x0 are dropped, and rd is meaningless without a write.
  always_comb begin
    o_ctrl          = w_raw;
    o_ctrl.regwrite = w_raw.regwrite & (i_rd != '0);
    o_ctrl.rd       = o_ctrl.regwrite ? i_rd : '0;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined main control: ID decode, load-use hazard, ID/EX -> EX/MEM -> MEM/WB bundles.
module pipe_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  ctrl_t            w_dec;
  logic             w_uses_rs1;
  logic             w_uses_rs2;
  logic             w_dec_illegal;
  logic             w_hazard;
  logic             w_stall;
  logic             w_bubble_in;
  logic             w_unused;

  ctrl_t            r_ex;
  ctrl_t            r_mem;
  ctrl_t            r_wb;
  logic             r_illegal_seen;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ctrl_decode u_decode (
    .i_opcode   (bus.opcode),
    .i_rd       (bus.rd),
    .o_ctrl     (w_dec),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_illegal  (w_dec_illegal)
  );

  // Load in EX whose result an ID source needs; a taken flush overrides it.
  assign w_hazard = r_ex.valid & r_ex.memread & (r_ex.rd != '0) &
                    ((w_uses_rs1 & (r_ex.rd == bus.rs1)) |
                     (w_uses_rs2 & (r_ex.rd == bus.rs2)));
  assign w_stall     = bus.id_valid & ~bus.ex_flush & w_hazard;
  assign w_bubble_in = w_stall | bus.ex_flush | ~bus.id_valid;

  // Stage registers: ID/EX takes a bubble or the decode, later stages always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= CTRL_BUBBLE;
      r_mem <= CTRL_BUBBLE;
      r_wb  <= CTRL_BUBBLE;
    end else begin
      r_ex  <= w_bubble_in ? CTRL_BUBBLE : w_dec;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // Sticky illegal flag and saturating stall/flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_seen <= 1'b0;
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (bus.id_valid && w_dec_illegal) r_illegal_seen <= 1'b1;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bus.ex_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall        = w_stall;
  assign bus.id_illegal   = bus.id_valid & w_dec_illegal;
  assign bus.ex_alusrc    = r_ex.alusrc;
  assign bus.ex_branch    = r_ex.branch;
  assign bus.ex_jump      = r_ex.jump;
  assign bus.ex_aluop     = r_ex.aluop;
  assign bus.ex_rd        = r_ex.rd;
  assign bus.mem_read     = r_mem.memread;
  assign bus.mem_write    = r_mem.memwrite;
  assign bus.mem_rd       = r_mem.rd;
  assign bus.wb_regwrite  = r_wb.regwrite;
  assign bus.wb_memtoreg  = r_wb.memtoreg;
  assign bus.wb_rd        = r_wb.rd;
  assign bus.illegal_seen = r_illegal_seen;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;

  // Bundle fields that no stage consumes at its own position.
  assign w_unused = ^{r_ex, r_mem, r_wb};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with 2-bit counters so saturation is reachable.
module tb_pipe_ctrl;

  localparam int unsigned TB_CNT_W = 2;

  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_LW    = 7'b0000011;
  localparam logic [6:0] T_SW    = 7'b0100011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_BAD   = 7'b1111111;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pipe_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (actual timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d, input logic fl);
    bus.id_valid = v;
    bus.opcode   = op;
    bus.rs1      = s1;
    bus.rs2      = s2;
    bus.rd       = d;
    bus.ex_flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.stall, bus.id_illegal, bus.ex_alusrc, bus.ex_branch, bus.ex_jump,
                bus.ex_aluop, bus.mem_read, bus.mem_write, bus.wb_regwrite, bus.wb_memtoreg,
                bus.ex_rd, bus.mem_rd, bus.wb_rd, bus.illegal_seen, bus.stall_cnt,
                bus.flush_cnt});
  endfunction

  function automatic logic [31:0] ex_outs();
    return 32'({bus.ex_alusrc, bus.ex_branch, bus.ex_jump, bus.ex_aluop, bus.ex_rd});
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #3;
    check_eq("reset_async_outs", all_outs(), 32'd0);
    repeat (2) tick();
    check_eq("reset_held_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    tick();

    // Load-use: LW x5 then ADD x6,x5,x1
    set_id(1'b1, T_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    #1 check_eq("a_lw_nostall", 32'(bus.stall), 32'd0);
    tick();
    check_eq("a_lw_ex_aluop", 32'(bus.ex_aluop), 32'd3);
    check_eq("a_lw_ex_alusrc", 32'(bus.ex_alusrc), 32'd1);
    check_eq("a_lw_ex_rd", 32'(bus.ex_rd), 32'd5);
    set_id(1'b1, T_R, 5'd5, 5'd1, 5'd6, 1'b0);
    #1 check_eq("a_stall", 32'(bus.stall), 32'd1);
    tick();
    check_eq("a_bubble_ex_rd", 32'(bus.ex_rd), 32'd0);
    check_eq("a_lw_mem_read", 32'(bus.mem_read), 32'd1);
    check_eq("a_lw_mem_rd", 32'(bus.mem_rd), 32'd5);
    check_eq("a_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    check_eq("a_stall_once", 32'(bus.stall), 32'd0);
    tick();
    check_eq("a_add_ex_rd", 32'(bus.ex_rd), 32'd6);
    check_eq("a_add_ex_alusrc", 32'(bus.ex_alusrc), 32'd0);
    check_eq("a_stall_cnt_hold", 32'(bus.stall_cnt), 32'd1);
    check_eq("a_lw_wb", 32'({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd}), 32'({2'b11, 5'd5}));
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check_eq("a_add_mem", 32'({bus.mem_read, bus.mem_rd}), 32'({1'b0, 5'd6}));
    tick();
    check_eq("a_add_wb", 32'({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd}), 32'({2'b10, 5'd6}));

    // LW x0 never hazards and never writes
    set_id(1'b1, T_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    check_eq("b_lw0_ex_rd", 32'(bus.ex_rd), 32'd0);
    set_id(1'b1, T_R, 5'd0, 5'd1, 5'd6, 1'b0);
    #1 check_eq("b_no_stall", 32'(bus.stall), 32'd0);
    tick();
    check_eq("b_add_ex_rd", 32'(bus.ex_rd), 32'd6);
    check_eq("b_lw0_mem", 32'({bus.mem_read, bus.mem_rd}), 32'({1'b1, 5'd0}));
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check_eq("b_lw0_wb", 32'({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd}), 32'({2'b01, 5'd0}));

    // Flush: BR in EX, then flush-vs-hazard, then JAL carried into MEM
    set_id(1'b1, T_BR, 5'd2, 5'd3, 5'd4, 1'b0);
    tick();
    check_eq("c_br_ex", ex_outs(), 32'({3'b010, 2'd2, 5'd0}));
    set_id(1'b1, T_R, 5'd2, 5'd3, 5'd7, 1'b1);
    #1 check_eq("c_br_flush_nostall", 32'(bus.stall), 32'd0);
    tick();
    check_eq("c_flush_ex_bubble", ex_outs(), 32'd0);
    check_eq("c_flush_cnt1", 32'(bus.flush_cnt), 32'd1);
    set_id(1'b1, T_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    set_id(1'b1, T_R, 5'd5, 5'd1, 5'd6, 1'b1);
    #1 check_eq("c_flush_wins", 32'(bus.stall), 32'd0);
    tick();
    check_eq("c_flush_bubble2", 32'(bus.ex_rd), 32'd0);
    check_eq("c_lw_to_mem", 32'({bus.mem_read, bus.mem_rd}), 32'({1'b1, 5'd5}));
    check_eq("c_flush_cnt2", 32'(bus.flush_cnt), 32'd2);
    check_eq("c_stall_cnt_kept", 32'(bus.stall_cnt), 32'd1);
    set_id(1'b1, T_JAL, 5'd0, 5'd0, 5'd1, 1'b0);
    tick();
    check_eq("c_jal_ex", ex_outs(), 32'({3'b001, 2'd1, 5'd1}));
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    check_eq("c_jal_to_mem", 32'(bus.mem_rd), 32'd1);
    check_eq("c_jal_flush_ex", ex_outs(), 32'd0);
    check_eq("c_flush_cnt3", 32'(bus.flush_cnt), 32'd3);
    tick();
    check_eq("c_flush_sat", 32'(bus.flush_cnt), 32'd3);
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    // rs2 use: SW stalls, I-ALU with rs2 field does not
    set_id(1'b1, T_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    set_id(1'b1, T_SW, 5'd1, 5'd5, 5'd9, 1'b0);
    #1 check_eq("d_sw_stall", 32'(bus.stall), 32'd1);
    tick();
    check_eq("d_stall_cnt2", 32'(bus.stall_cnt), 32'd2);
    tick();
    check_eq("d_sw_ex", ex_outs(), 32'({3'b100, 2'd1, 5'd0}));
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check_eq("d_sw_mem_write", 32'(bus.mem_write), 32'd1);
    set_id(1'b1, T_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    set_id(1'b1, T_I, 5'd1, 5'd5, 5'd8, 1'b0);
    #1 check_eq("d_ialu_nostall", 32'(bus.stall), 32'd0);
    tick();
    check_eq("d_ialu_ex", ex_outs(), 32'({3'b100, 2'd2, 5'd8}));

    // LUI, JALR to x0, and JALR rs1 hazard
    set_id(1'b1, T_LUI, 5'd0, 5'd0, 5'd3, 1'b0);
    tick();
    check_eq("e_lui_ex", ex_outs(), 32'({3'b100, 2'd1, 5'd3}));
    set_id(1'b1, T_JALR, 5'd5, 5'd0, 5'd0, 1'b0);
    tick();
    check_eq("e_jalr_x0_ex", ex_outs(), 32'({3'b101, 2'd1, 5'd0}));
    set_id(1'b1, T_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    set_id(1'b1, T_JALR, 5'd5, 5'd0, 5'd1, 1'b0);
    #1 check_eq("e_jalr_rs1_stall", 32'(bus.stall), 32'd1);
    tick();
    check_eq("e_stall_cnt3", 32'(bus.stall_cnt), 32'd3);
    tick();
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Illegal opcode
    set_id(1'b1, T_BAD, 5'd0, 5'd0, 5'd4, 1'b0);
    #1 check_eq("f_id_illegal", 32'(bus.id_illegal), 32'd1);
    check_eq("f_seen_not_yet", 32'(bus.illegal_seen), 32'd0);
    tick();
    check_eq("f_seen_set", 32'(bus.illegal_seen), 32'd1);
    check_eq("f_ex_bubble", ex_outs(), 32'd0);
    set_id(1'b0, T_BAD, 5'd0, 5'd0, 5'd4, 1'b0);
    #1 check_eq("f_invalid_not_illegal", 32'(bus.id_illegal), 32'd0);
    repeat (3) tick();
    check_eq("f_seen_sticky", 32'(bus.illegal_seen), 32'd1);

    // More stalls with the counter already saturated
    for (int k = 0; k < 2; k++) begin
      set_id(1'b1, T_LW, 5'd1, 5'd0, 5'd5, 1'b0);
      tick();
      set_id(1'b1, T_R, 5'd5, 5'd1, 5'd6, 1'b0);
      #1 check_eq("g_stall", 32'(bus.stall), 32'd1);
      tick();
      tick();
    end
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_eq("g_stall_sat", 32'(bus.stall_cnt), 32'd3);

    // Reset in the middle of a stall
    set_id(1'b1, T_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    set_id(1'b1, T_R, 5'd5, 5'd1, 5'd6, 1'b0);
    #1 check_eq("h_pre_stall", 32'(bus.stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_eq("h_reset_async", all_outs(), 32'd0);
    tick();
    rst_n = 1'b1;
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check_eq("h_no_partial", all_outs(), 32'd0);
    repeat (2) tick();
    check_eq("h_no_partial_wb", all_outs(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
